// File: rtl/i2c_master_byte.sv
// i2c_master_byte: single-master I2C controller issuing one-byte read or
// write transactions to a 7-bit-addressed slave over open-drain SDA/SCL.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | lines released, cmd_ready high, waiting for a command
// START    | SDA falls while SCL is high, then SCL is pulled low
// ADDR     | shift out {addr[6:0], rw}, MSB first
// ADDR_ACK | SDA released, slave ACK/NACK sampled
// WRITE    | shift out the write byte, MSB first
// WR_ACK   | SDA released, slave ACK/NACK on the data byte sampled
// READ     | SDA released, 8 bits shifted in MSB first
// RD_NACK  | master leaves SDA released (NACK), received byte published
// STOP     | SDA rises while SCL is high, bus left idle
// DONE     | one-cycle done pulse, then back to IDLE
module i2c_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       ack_err,
  output logic       busy,
  inout  wire        sda,
  inout  wire        scl
);

  localparam int QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_NACK, STOP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rw_q, rw_d;
  logic          samp_q, samp_d;
  logic          ack_err_q, ack_err_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          sda_low_q, sda_low_d;
  logic          scl_low_q, scl_low_d;
  logic          sda_s1_q, sda_s2_q;

  logic run, tick, bit_end;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign ack_err   = ack_err_q;
  assign rdata     = rdata_q;

  // Open-drain: only ever pull low or release.
  assign sda = sda_low_q ? 1'b0 : 1'bz;
  assign scl = scl_low_q ? 1'b0 : 1'bz;

  // Register file for FSM, timing counters, shifters and line drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      wdata_q   <= 8'h00;
      rw_q      <= 1'b0;
      samp_q    <= 1'b1;
      ack_err_q <= 1'b0;
      rdata_q   <= 8'h00;
      sda_low_q <= 1'b0;
      scl_low_q <= 1'b0;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      samp_q    <= samp_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
      sda_low_q <= sda_low_d;
      scl_low_q <= scl_low_d;
      sda_s1_q  <= sda;
      sda_s2_q  <= sda_s1_q;
    end
  end

  // Next-state logic: quarter timing, bit sequencing and data capture.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    samp_d    = samp_q;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;

    run     = (state_q != IDLE) && (state_q != DONE);
    tick    = run && (qcnt_q == Q_LAST);
    bit_end = tick && (phase_q == 2'd3);

    if (run) begin
      qcnt_d = tick ? '0 : qcnt_q + QW'(1);
    end
    if (tick) begin
      phase_d = phase_q + 2'd1;
    end
    // Sample point is the start of Q3, after SCL has been high for a quarter.
    if (tick && (phase_q == 2'd2)) begin
      samp_d = sda_s2_q;
      if (state_q == READ) begin
        rx_d = {rx_q[6:0], sda_s2_q};
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = START;
          tx_d      = {cmd_addr, cmd_rw};
          wdata_d   = cmd_wdata;
          rw_d      = cmd_rw;
          ack_err_d = 1'b0;
          qcnt_d    = '0;
          phase_d   = 2'd0;
          bit_d     = 3'd0;
        end
      end
      START: begin
        if (bit_end) state_d = ADDR;
      end
      ADDR: begin
        if (bit_end) begin
          tx_d  = {tx_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        if (bit_end) begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = STOP;
          end else if (rw_q) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
            tx_d    = wdata_q;
          end
        end
      end
      WRITE: begin
        if (bit_end) begin
          tx_d  = {tx_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = WR_ACK;
        end
      end
      WR_ACK: begin
        if (bit_end) begin
          if (samp_q) ack_err_d = 1'b1;
          state_d = STOP;
        end
      end
      READ: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RD_NACK;
        end
      end
      RD_NACK: begin
        if (bit_end) begin
          rdata_d = rx_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        qcnt_d  = '0;
        phase_d = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drive is derived from the upcoming state/phase so SDA and SCL
  // change exactly on quarter boundaries from glitch-free flops.
  always_comb begin
    sda_low_d = 1'b0;
    scl_low_d = 1'b0;
    case (state_d)
      START: begin
        sda_low_d = phase_d[1];
      end
      ADDR, WRITE: begin
        sda_low_d = ~tx_d[7];
        scl_low_d = ~phase_d[1];
      end
      ADDR_ACK, WR_ACK, READ, RD_NACK: begin
        scl_low_d = ~phase_d[1];
      end
      STOP: begin
        sda_low_d = ~phase_d[1];
        scl_low_d = (phase_d == 2'd0);
      end
      default: begin
        sda_low_d = 1'b0;
        scl_low_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a behavioural open-drain slave.
module tb_i2c_master_byte;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic [7:0] rdata;
  logic       done;
  logic       ack_err;
  logic       busy;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  logic s_low = 1'b0;
  assign sda = s_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rdata     (rdata),
    .done      (done),
    .ack_err   (ack_err),
    .busy      (busy),
    .sda       (sda),
    .scl       (scl)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Slave model state.
  logic       addr_ack_en = 1'b1;
  logic       data_ack_en = 1'b1;
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] got[$];
  logic       master_nack = 1'b0;
  int         starts = 0;
  int         stops = 0;
  time        t_start = 0;
  time        t_stop = 0;
  int         bitn = -1;
  int         byten = 0;
  logic       active = 1'b0;
  logic       rw_s = 1'b0;
  logic [7:0] sh = 8'h00;
  logic       psda = 1'b1;
  logic       pscl = 1'b1;

  int  done_cnt = 0;
  int  acc_cnt = 0;
  time t_acc_mon = 0;
  time t_acc = 0;

  // Slave: decodes START/STOP and bits from sampled bus, ACKs and returns read data.
  always @(posedge clk) begin
    if (pscl && scl && psda && !sda) begin
      starts++;
      t_start = $time;
      bitn = -1;
      byten = 0;
      active = 1'b1;
      s_low <= 1'b0;
    end else if (pscl && scl && !psda && sda) begin
      stops++;
      t_stop = $time;
    end else if (!pscl && scl) begin
      if (bitn >= 0 && bitn < 8) begin
        sh = {sh[6:0], sda};
        if (bitn == 7) begin
          got.push_back(sh);
          if (byten == 0) rw_s = sh[0];
        end
      end else if (bitn == 8 && byten == 1 && rw_s) begin
        master_nack = sda;
      end
    end else if (pscl && !scl) begin
      if (bitn == 8) begin
        bitn = 0;
        byten++;
      end else begin
        bitn++;
      end
      if (bitn == 8 && byten == 0) begin
        s_low <= addr_ack_en;
        active = addr_ack_en;
      end else if (bitn == 8 && byten == 1 && !rw_s) begin
        s_low <= active && data_ack_en;
      end else if (bitn < 8 && byten == 1 && rw_s) begin
        s_low <= active && !rd_byte[7-bitn];
      end else begin
        s_low <= 1'b0;
      end
    end
    psda = sda;
    pscl = scl;
  end

  // Handshake and done-pulse monitors.
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      t_acc_mon = $time;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd_rw = rw;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    got.delete();
    @(posedge clk);
    t_acc = $time;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output time tn);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    tn = $time;
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    time tn;
    time tn1;
    time stop1;
    int  dc0;
    int  st0;
    int  ac0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    chk("rst_scl", {31'd0, scl}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x5A to 0x2A, slave ACKs everything.
    addr_ack_en = 1'b1;
    data_ack_en = 1'b1;
    dc0 = done_cnt;
    st0 = stops;
    start_cmd(1'b0, 7'h2A, 8'h5A);
    @(negedge clk);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_ready_low", {31'd0, cmd_ready}, 32'd0);
    wait_done(tn);
    chk("wr_len", 32'((tn - 5 - t_acc) / 10), 32'd320);
    chk("wr_ack_err", {31'd0, ack_err}, 32'd0);
    chk("wr_nbytes", got.size(), 32'd2);
    chk("wr_addr_byte", {24'd0, got[0]}, 32'h54);
    chk("wr_data_byte", {24'd0, got[1]}, 32'h5A);
    chk("wr_stop", stops - st0, 32'd1);
    @(negedge clk);
    chk("wr_done_1cyc", {31'd0, done}, 32'd0);
    chk("wr_done_cnt", done_cnt - dc0, 32'd1);

    // Read from 0x2A, slave returns 0xC3.
    rd_byte = 8'hC3;
    master_nack = 1'b0;
    start_cmd(1'b1, 7'h2A, 8'hFF);
    wait_done(tn);
    chk("rd_len", 32'((tn - 5 - t_acc) / 10), 32'd320);
    chk("rd_addr_byte", {24'd0, got[0]}, 32'h55);
    chk("rd_bus_byte", {24'd0, got[1]}, 32'hC3);
    chk("rd_master_nack", {31'd0, master_nack}, 32'd1);
    chk("rd_rdata", {24'd0, rdata}, 32'hC3);
    chk("rd_ack_err", {31'd0, ack_err}, 32'd0);

    // Address NACK: no slave response.
    addr_ack_en = 1'b0;
    st0 = stops;
    start_cmd(1'b0, 7'h2A, 8'h11);
    wait_done(tn);
    chk("an_len", 32'((tn - 5 - t_acc) / 10), 32'd176);
    chk("an_ack_err", {31'd0, ack_err}, 32'd1);
    chk("an_nbytes", got.size(), 32'd1);
    chk("an_stop", stops - st0, 32'd1);
    @(negedge clk);
    chk("an_ack_err_hold", {31'd0, ack_err}, 32'd1);

    // Data NACK on a write to address 0x00.
    addr_ack_en = 1'b1;
    data_ack_en = 1'b0;
    start_cmd(1'b0, 7'h00, 8'hA5);
    @(negedge clk);
    chk("dn_ack_err_clr", {31'd0, ack_err}, 32'd0);
    wait_done(tn);
    chk("dn_ack_err", {31'd0, ack_err}, 32'd1);
    chk("dn_rdata_kept", {24'd0, rdata}, 32'hC3);
    chk("dn_addr_byte", {24'd0, got[0]}, 32'h00);
    chk("dn_data_byte", {24'd0, got[1]}, 32'hA5);

    // Back-to-back: cmd_valid held with varying payloads while busy.
    data_ack_en = 1'b1;
    ac0 = acc_cnt;
    @(negedge clk);
    got.delete();
    cmd_rw = 1'b0;
    cmd_addr = 7'h2A;
    cmd_wdata = 8'h11;
    cmd_valid = 1'b1;
    @(posedge clk);
    t_acc = $time;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cmd_rw = 1'($urandom);
      cmd_addr = 7'($urandom);
      cmd_wdata = 8'($urandom);
    end
    @(negedge clk);
    cmd_rw = 1'b0;
    cmd_addr = 7'h15;
    cmd_wdata = 8'h3C;
    wait_done(tn1);
    stop1 = t_stop;
    chk("b2b_len1", 32'((tn1 - 5 - t_acc) / 10), 32'd320);
    chk("b2b_first_addr", {24'd0, got[0]}, 32'h54);
    chk("b2b_first_data", {24'd0, got[1]}, 32'h11);
    chk("b2b_single_acc", acc_cnt - ac0, 32'd1);
    got.delete();
    @(posedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("b2b_second_acc", acc_cnt - ac0, 32'd2);
    chk("b2b_acc_time", 32'(t_acc_mon - tn1), 32'd15);
    t_acc = t_acc_mon;
    wait_done(tn);
    chk("b2b_len2", 32'((tn - 5 - t_acc) / 10), 32'd320);
    chk("b2b_second_addr", {24'd0, got[0]}, 32'h2A);
    chk("b2b_second_data", {24'd0, got[1]}, 32'h3C);
    chk("b2b_idle_gap", {31'd0, (t_start - stop1) >= 80}, 32'd1);

    // Reset in the middle of the address byte.
    start_cmd(1'b0, 7'h2A, 8'h5A);
    dc0 = done_cnt;
    repeat (18) @(negedge clk);
    chk("mr_scl_low", {31'd0, scl}, 32'd0);
    chk("mr_sda_low", {31'd0, sda}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_sda_rel", {31'd0, sda}, 32'd1);
    chk("mr_scl_rel", {31'd0, scl}, 32'd1);
    chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_rdata", {24'd0, rdata}, 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("mr_no_done", done_cnt - dc0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
